// File: rtl/sc_et_checker_if.sv
// rtl/sc_et_checker_if.sv - stream/checkpoint inputs and result outputs of the early-termination checker
interface sc_et_checker_if #(
    parameter int TW = 8
);
    localparam int KW = $clog2(TW + 1);

    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          pulse;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [TW:0]   est;
    logic [KW-1:0] len_log2;

    modport master (
        output start, bit_in, bit_valid, pulse,
        input  busy, done, timeout, est, len_log2
    );

    modport slave (
        input  start, bit_in, bit_valid, pulse,
        output busy, done, timeout, est, len_log2
    );
endinterface

// File: rtl/sc_et_checker.sv
// rtl/sc_et_checker.sv - stops an SC stream once power-of-two checkpoint estimates settle
module sc_et_checker #(
    parameter int TW     = 8,
    parameter int THRESH = 0,
    parameter int MIN_K  = 2,
    parameter int CONSEC = 2
) (
    input  logic           clk,
    input  logic           rst,
    sc_et_checker_if.slave bus
);
    localparam int KW = $clog2(TW + 1);
    localparam int CW = $clog2(CONSEC + 1);

    localparam logic [KW-1:0] K_LAST = KW'(TW);
    localparam logic [KW-1:0] K_MIN  = KW'(MIN_K);
    localparam logic [CW-1:0] C_TERM = CW'(CONSEC);
    localparam logic [TW+1:0] D_MAX  = (TW + 2)'(THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [TW:0]          ones;
    logic [TW:0]          prev_est;
    logic [TW:0]          est_q;
    logic [KW-1:0]        k;
    logic [KW-1:0]        len_q;
    logic [CW-1:0]        cons;
    logic                 busy_q;
    logic                 done_q;
    logic                 timeout_q;

    logic [TW:0]          ones_n;
    logic [TW:0]          e;
    logic signed [TW+1:0] diff;
    logic [TW+1:0]        mag;
    logic                 stable;
    logic [CW-1:0]        cons_n;

    // Scaling by 2^(TW-k) normalizes the count of a 2^k-bit prefix to 2^TW = 1.0
    always_comb begin
        ones_n = ones + {{TW{1'b0}}, bus.bit_in};
        e      = ones_n << (K_LAST - k);
        diff   = $signed({1'b0, e}) - $signed({1'b0, prev_est});
        mag    = diff[TW+1] ? $unsigned(-diff) : $unsigned(diff);
        stable = (k >= K_MIN) && (mag <= D_MAX);
        cons_n = stable ? cons + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ones      <= '0;
            prev_est  <= '0;
            est_q     <= '0;
            k         <= '0;
            len_q     <= '0;
            cons      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (bus.start) begin
            state     <= RUN;
            ones      <= '0;
            prev_est  <= '0;
            k         <= '0;
            cons      <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.bit_valid) begin
                        ones <= ones_n;
                        if (bus.pulse) begin
                            cons     <= cons_n;
                            prev_est <= e;
                            est_q    <= e;
                            len_q    <= k;
                            k        <= k + 1'b1;
                            // Convergence wins over the length limit when both land together
                            if (cons_n == C_TERM) begin
                                state     <= DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                timeout_q <= 1'b0;
                            end else if (k == K_LAST) begin
                                state     <= DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    state <= state;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;
    assign bus.est      = est_q;
    assign bus.len_log2 = len_q;
endmodule

// File: tb/tb_sc_et_checker.sv
// tb/tb_sc_et_checker.sv - directed bench with a stream-prefix reference model for two CONSEC settings
module tb_sc_et_checker;
    localparam int TW     = 8;
    localparam int THRESH = 0;
    localparam int MIN_K  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_et_checker_if #(.TW(TW)) bus_a ();
    sc_et_checker_if #(.TW(TW)) bus_b ();

    sc_et_checker #(.TW(TW), .THRESH(THRESH), .MIN_K(MIN_K), .CONSEC(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sc_et_checker #(.TW(TW), .THRESH(THRESH), .MIN_K(MIN_K), .CONSEC(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_b.start     = bus_a.start;
    assign bus_b.bit_in    = bus_a.bit_in;
    assign bus_b.bit_valid = bus_a.bit_valid;
    assign bus_b.pulse     = bus_a.pulse;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the estimate is the ones-fraction of the whole prefix seen so far
    int m_run[2], m_done[2], m_tmo[2], m_len[2], m_ones[2];
    int m_cons[2], m_prev[2], m_est[2], m_k[2];

    function automatic int consec_of(input int c);
        return (c == 0) ? 2 : 16;
    endfunction

    task automatic model_step(input int c);
        int kk, e, d;
        if (rst) begin
            m_run[c] = 0; m_done[c] = 0; m_tmo[c] = 0; m_len[c] = 0; m_ones[c] = 0;
            m_cons[c] = 0; m_prev[c] = 0; m_est[c] = 0; m_k[c] = 0;
        end else if (bus_a.start) begin
            m_run[c] = 1; m_done[c] = 0; m_tmo[c] = 0;
            m_len[c] = 0; m_ones[c] = 0; m_cons[c] = 0; m_prev[c] = 0;
        end else if (m_run[c] == 1 && bus_a.bit_valid) begin
            m_len[c]++;
            m_ones[c] += int'(bus_a.bit_in);
            if (bus_a.pulse) begin
                kk = 0;
                while ((1 << kk) < m_len[c]) kk++;
                e = m_ones[c] * (1 << TW) / m_len[c];
                d = e - m_prev[c];
                if (d < 0) d = -d;
                if (kk >= MIN_K && d <= THRESH) m_cons[c]++;
                else m_cons[c] = 0;
                m_prev[c] = e;
                m_est[c]  = e;
                m_k[c]    = kk;
                if (m_cons[c] == consec_of(c)) begin
                    m_run[c] = 0; m_done[c] = 1; m_tmo[c] = 0;
                end else if (kk == TW) begin
                    m_run[c] = 0; m_done[c] = 1; m_tmo[c] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        chk("a_busy", int'(bus_a.busy), m_run[0]);
        chk("a_done", int'(bus_a.done), m_done[0]);
        chk("a_timeout", int'(bus_a.timeout), m_tmo[0]);
        chk("a_est", int'(bus_a.est), m_est[0]);
        chk("a_len_log2", int'(bus_a.len_log2), m_k[0]);
        chk("b_busy", int'(bus_b.busy), m_run[1]);
        chk("b_done", int'(bus_b.done), m_done[1]);
        chk("b_timeout", int'(bus_b.timeout), m_tmo[1]);
        chk("b_est", int'(bus_b.est), m_est[1]);
        chk("b_len_log2", int'(bus_b.len_log2), m_k[1]);
    end

    int cnt = 0;

    task automatic do_start();
        bus_a.start     = 1'b1;
        bus_a.bit_valid = 1'b0;
        bus_a.pulse     = 1'b0;
        @(negedge clk);
        bus_a.start = 1'b0;
        cnt = 0;
    endtask

    // mode 0: all ones, 1: all zeros, 2: alternating 1,0,1,0,...
    task automatic send_n(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus_a.bit_in    = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((cnt % 2) == 0);
            cnt++;
            bus_a.bit_valid = 1'b1;
            bus_a.pulse     = ((cnt & (cnt - 1)) == 0);
            @(negedge clk);
            bus_a.bit_valid = 1'b0;
            bus_a.pulse     = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.bit_valid = 1'b0;
            bus_a.pulse     = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_result(input string nm, input int done, input int est, input int len, input int tmo);
        chk({nm, "_done"}, int'(bus_a.done), done);
        chk({nm, "_est"}, int'(bus_a.est), est);
        chk({nm, "_len_log2"}, int'(bus_a.len_log2), len);
        chk({nm, "_timeout"}, int'(bus_a.timeout), tmo);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.bit_in = 1'b0; bus_a.bit_valid = 1'b0; bus_a.pulse = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus_a.busy), 0);
        chk_result("rst", 0, 0, 0, 0);
        rst = 1'b0;
        idle(2);

        do_start();
        chk("ones_busy", int'(bus_a.busy), 1);
        send_n(7, 0);
        chk("ones_done_early", int'(bus_a.done), 0);
        send_n(1, 0);
        chk_result("ones", 1, 256, 3, 0);
        chk("ones_busy_end", int'(bus_a.busy), 0);
        idle(3);
        chk_result("ones_hold", 1, 256, 3, 0);

        do_start();
        chk("alt_done_clr", int'(bus_a.done), 0);
        send_n(8, 2);
        chk_result("alt", 1, 128, 3, 0);

        do_start();
        send_n(5, 2);
        for (int i = 0; i < 3; i++) begin
            bus_a.bit_valid = 1'b0;
            bus_a.pulse     = (i == 1);
            @(negedge clk);
            chk("gap_busy", int'(bus_a.busy), 1);
        end
        bus_a.pulse = 1'b0;
        send_n(3, 2);
        chk_result("gap", 1, 128, 3, 0);

        do_start();
        send_n(5, 0);
        chk("pre_rst_est", int'(bus_a.est), 256);
        chk("pre_rst_len", int'(bus_a.len_log2), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(bus_a.busy), 0);
        chk_result("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        send_n(8, 0);
        chk_result("after_rst", 1, 256, 3, 0);

        do_start();
        send_n(6, 0);
        do_start();
        send_n(7, 0);
        chk("restart_done_early", int'(bus_a.done), 0);
        send_n(1, 0);
        chk_result("restart", 1, 256, 3, 0);

        do_start();
        send_n(255, 1);
        chk("max_b_done_early", int'(bus_b.done), 0);
        send_n(1, 1);
        chk("max_b_done", int'(bus_b.done), 1);
        chk("max_b_timeout", int'(bus_b.timeout), 1);
        chk("max_b_est", int'(bus_b.est), 0);
        chk("max_b_len_log2", int'(bus_b.len_log2), 8);
        chk_result("zeros_a", 1, 0, 3, 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sc_et_checker.md
Name: sc_et_checker

Overview:
Early-termination checker for stochastic-computing bitstreams. It sits directly downstream of the power-of-two checkpoint pulse generator. It accumulates the ones count of an SC output stream. At each power-of-two stream length it forms a normalized estimate and compares it with the previous checkpoint's estimate. It declares termination once consecutive checkpoint estimates agree within a threshold, or when the maximum stream length is reached.

Parameters:
TW, 8, log2 of maximum stream length; estimate precision is TW+1 bits.
THRESH, 0, max allowed |est_k - est_(k-1)| (in normalized TW-bit units) for a checkpoint to count as stable.
MIN_K, 2, checkpoint index below which stability is not counted (guards tiny N).
CONSEC, 2, number of consecutive stable checkpoints required to terminate.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  asynchronous active-high reset.
start  in  1  begin/restart a termination run (single-cycle pulse).
bit_in  in  1  SC stream bit.
bit_valid  in  1  bit_in and pulse qualifier.
pulse  in  1  checkpoint strobe from the pow2 pulse generator; high on the 1st, 2nd, 4th, 8th, ... valid bit after start.
busy  out  1  high in RUN.
done  out  1  high in DONE, held until start.
timeout  out  1  high in DONE only if termination was by maximum length.
est  out  TW+1  last checkpoint estimate = ones << (TW-k); 2^TW represents 1.0.
len_log2  out  $clog2(TW+1)  k of the terminating checkpoint (stream length = 2^k).

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - ones, k, prev_est, cons, est, len_log2 are all 0.
  - busy, done and timeout are all 0.
- States: IDLE, RUN, DONE.
  - IDLE: on start, go to RUN.
  - RUN: on termination, go to DONE.
  - DONE: on start, go to RUN.
- Start from any state clears ones, k, prev_est and cons, and enters RUN next cycle.
  - start in RUN aborts and restarts the run.
- bit_valid and pulse are ignored outside RUN, and pulse is ignored without bit_valid.
- RUN, per valid bit:
  - ones_n = ones + bit_in.
  - ones is TW+1 bits wide and never exceeds 2^TW.
- RUN, valid bit with pulse (k = checkpoints already seen, N = 2^k):
  - e = ones_n << (TW-k).
  - If k >= 1: d = |e - prev_est|.
  - If k >= MIN_K and d <= THRESH: cons++.
  - Otherwise: cons = 0.
  - Then prev_est = e, est = e, len_log2 = k, k++.
- Termination is evaluated at the checkpoint cycle using the updated cons:
  - If cons_n == CONSEC: go to DONE with timeout=0.
  - Else if k == TW: go to DONE with timeout=1.
  - Convergence has priority when both hold.
- Latency: done/est/len_log2 are registered and valid the cycle after the terminating bit. A pulse without a bit on the same cycle is not a checkpoint.
- A pulse arriving when k > TW cannot occur, because DONE is entered at k == TW.
- Gaps in bit_valid stall accumulation; state is held.
- DONE holds est, len_log2 and timeout stable until start or rst.
- Subtraction for d uses TW+2-bit signed arithmetic, with no wrap.

Test Plan:
- TW=8, THRESH=0, MIN_K=2, CONSEC=2; start, then all-ones stream with pulses at valid bits 1,2,4,8 -> estimates 256,256,256,256; done rises the cycle after bit 8; est=256, len_log2=3, timeout=0.
- Same parameters, stream 1,0,1,0,... -> estimates 256,128,128,128; cons=1 at k=2 and 2 at k=3; done after bit 8, est=128, len_log2=3, timeout=0.
- CONSEC=16, all-zeros stream of 256 valid bits -> no convergence; done after bit 256, timeout=1, est=0, len_log2=8.
- Alternating stream with bit_valid deasserted for 3 cycles between bits 5 and 6 -> result identical to the ungapped case (est=128, len_log2=3); busy stays high through the gap.
- rst asserted after bit 5 of the all-ones run -> all outputs 0 immediately and state IDLE; a new start plus all-ones stream gives done after bit 8 with est=256.
- start pulsed in RUN after bit 6, then all-ones stream -> counters cleared; terminates 8 valid bits after the restart with est=256, len_log2=3.
